// File: rtl/note_sequencer.sv
// note_sequencer: writable note sheet played back on a tempo tick.
// Define SEQ_PAUSE_EN to add the pause input (freezes PLAY/GAP timing).
module note_sequencer #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned NOTE_W    = 3,
  parameter int unsigned DUR_W     = 8,
  parameter int unsigned GAP_TICKS = 20,
  parameter int unsigned REST_CODE = 7,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
`ifdef SEQ_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [ADDR_W:0]   song_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [DUR_W-1:0]  wr_dur,
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] index
);

  localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int unsigned TICK_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
  localparam logic [TICK_W-1:0] GAP_LD   = TICK_W'(GAP_TICKS);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [NOTE_W-1:0] REST     = NOTE_W'(REST_CODE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [ADDR_W-1:0]       index_q, index_d;
  logic [ADDR_W:0]         len_q, len_d;
  logic [NOTE_W-1:0]       note_q, note_d;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic [NOTE_W+DUR_W-1:0] mem_q [DEPTH];
  logic [NOTE_W+DUR_W-1:0] rd_q;
  logic [NOTE_W-1:0]       rd_note;
  logic [DUR_W-1:0]        rd_dur;
  logic                    hold;
  logic                    adv;
  logic                    idx_last;
  logic                    idx_ge;
  logic                    sounding;

`ifdef SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign rd_note  = rd_q[NOTE_W+DUR_W-1:DUR_W];
  assign rd_dur   = rd_q[DUR_W-1:0];
  assign idx_last = ({1'b0, index_q} == (len_q - LEN_ONE));
  assign idx_ge   = ({1'b0, index_q} >= len_q);

  // Sheet storage; the read follows the next index so FETCH sees it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= {wr_note, wr_dur};
    end
    rd_q <= mem_q[index_d];
  end

  // Playback FSM with prescaler and remaining-tick counter.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    len_d   = len_q;
    note_d  = note_q;
    pre_d   = pre_q;
    tick_d  = tick_q;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          len_d   = song_len;
          index_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (idx_ge || (rd_dur == '0)) begin
          state_d = S_DONE;
        end else begin
          note_d  = rd_note;
          tick_d  = TICK_W'(rd_dur);
          pre_d   = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY, S_GAP: begin
        if (!hold) begin
          if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (tick_q == TICK_ONE) begin
              if ((state_q == S_PLAY) && (GAP_TICKS > 0)) begin
                tick_d  = GAP_LD;
                state_d = S_GAP;
              end else begin
                adv = 1'b1;
              end
            end else begin
              tick_d = tick_q - TICK_ONE;
            end
          end else begin
            pre_d = pre_q + PRE_ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (adv) begin
      if (idx_last) begin
        if (loop) begin
          index_d = '0;
          state_d = S_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end else begin
        index_d = index_q + IDX_ONE;
        state_d = S_FETCH;
      end
    end
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      index_d = '0;
      pre_d   = '0;
      tick_d  = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      index_q <= '0;
      len_q   <= '0;
      note_q  <= REST;
      pre_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      len_q   <= len_d;
      note_q  <= note_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
    end
  end

  assign sounding   = (state_q == S_PLAY) && !hold;
  assign note       = sounding ? note_q : REST;
  assign note_valid = sounding;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign index      = index_q;

endmodule
